// File: rtl/timing_state_generator.sv
// One-hot instruction timing-state generator (T0..Tn) with post-reset startup
// sequence and vector-fetch flags. Optional macro: TIMING_CYCLE_COUNT_EN adds Cycle_Count.
module timing_state_generator #(
   parameter int NUM_T_STATES     = 6,
   parameter int RESET_SEQ_CYCLES = 7
) (
   input  logic                    GlobalClock,
   input  logic                    Reset_n,
   input  logic                    ClockEnable,
   input  logic                    Rdy,
   input  logic                    Read_Cycle,
   input  logic                    Last_Cycle,
   output logic [NUM_T_STATES-1:0] T_State,
   output logic                    Sync,
   output logic                    Reset_Active,
   output logic [1:0]              Vector_Fetch,
   output logic                    Timing_Error
`ifdef TIMING_CYCLE_COUNT_EN
   ,
   output logic [15:0]             Cycle_Count
`endif
);

   typedef enum logic {
      RST_SEQ = 1'b0,
      RUN     = 1'b1
   } state_e;

   localparam int CW = $clog2(RESET_SEQ_CYCLES + 1);
   localparam logic [CW-1:0] VF_LO_CNT = CW'(RESET_SEQ_CYCLES - 2);
   localparam logic [CW-1:0] VF_HI_CNT = CW'(RESET_SEQ_CYCLES - 1);
   localparam logic [CW-1:0] SEQ_DONE  = CW'(RESET_SEQ_CYCLES);
   localparam logic [NUM_T_STATES-1:0] T0_OH = NUM_T_STATES'(1);
   localparam logic [NUM_T_STATES-1:0] T1_OH = NUM_T_STATES'(2);

   state_e                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [NUM_T_STATES-1:0] t_q, t_d;
   logic                    sync_q, sync_d;
   logic                    resetActive_q, resetActive_d;
   logic [1:0]              vf_q, vf_d;
   logic                    err_q, err_d;
   logic                    stall;
   logic                    tick;

   // The vector-fetch cycles are real bus reads, so they stall like RUN reads do.
   assign stall = ~Rdy & Read_Cycle & ((state_q == RUN) | (vf_q != 2'b00));
   assign tick  = ClockEnable & ~stall;

   always_ff @(posedge GlobalClock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q       <= RST_SEQ;
         cnt_q         <= '0;
         t_q           <= '0;
         sync_q        <= 1'b0;
         resetActive_q <= 1'b1;
         vf_q          <= 2'b00;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         t_q           <= t_d;
         sync_q        <= sync_d;
         resetActive_q <= resetActive_d;
         vf_q          <= vf_d;
         err_q         <= err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      t_d           = t_q;
      sync_d        = sync_q;
      resetActive_d = resetActive_q;
      vf_d          = vf_q;
      err_d         = err_q;

      if (tick) begin
         unique case (state_q)
            RST_SEQ: begin
               // Flags are decided from the count before this tick's increment.
               vf_d = 2'b00;
               if (cnt_q == SEQ_DONE) begin
                  state_d       = RUN;
                  t_d           = T1_OH;
                  sync_d        = 1'b1;
                  resetActive_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == VF_LO_CNT) begin
                     vf_d = 2'b01;
                  end else if (cnt_q == VF_HI_CNT) begin
                     vf_d = 2'b10;
                  end
               end
            end
            RUN: begin
               vf_d          = 2'b00;
               resetActive_d = 1'b0;
               if (t_q[0]) begin
                  t_d = T1_OH;
               end else if (Last_Cycle || t_q[NUM_T_STATES-1]) begin
                  t_d = T0_OH;
                  if (t_q[NUM_T_STATES-1] && !Last_Cycle) begin
                     err_d = 1'b1;
                  end
               end else begin
                  t_d = {t_q[NUM_T_STATES-2:0], 1'b0};
               end
               sync_d = t_d[1];
            end
            default: begin
               state_d = RST_SEQ;
            end
         endcase
      end
   end

   assign T_State      = t_q;
   assign Sync         = sync_q;
   assign Reset_Active = resetActive_q;
   assign Vector_Fetch = vf_q;
   assign Timing_Error = err_q;

`ifdef TIMING_CYCLE_COUNT_EN
   logic [15:0] cycleCount_q, cycleCount_d;

   always_comb begin
      cycleCount_d = cycleCount_q;
      if (tick && (state_q == RUN)) begin
         cycleCount_d = cycleCount_q + 16'd1;
      end
   end

   always_ff @(posedge GlobalClock or negedge Reset_n) begin
      if (!Reset_n) begin
         cycleCount_q <= 16'd0;
      end else begin
         cycleCount_q <= cycleCount_d;
      end
   end

   assign Cycle_Count = cycleCount_q;
`endif

endmodule
